// File: rtl/afifo_wptr_full.sv
// Write-domain pointer logic for an async FIFO: binary write address, registered Gray
// pointer for the read-side synchronizer, full and sticky overflow flags.
// Optional registered almost-full flag is built only when AFIFO_WALMOST_FULL_EN is defined.
module afifo_wptr_full #(
  parameter int ADDR_W       = 4,
  parameter int AFULL_THRESH = 2**ADDR_W - 2
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              winc_i,
  input  logic [ADDR_W:0]   wq2_rptr_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [ADDR_W:0]   wptr_o,
  output logic              wfull_o,
  output logic              wovf_o,
  output logic              walmost_full_o
);

  if (ADDR_W < 2 || AFULL_THRESH < 0 || AFULL_THRESH > 2**ADDR_W) begin : g_bad_params
    $error("afifo_wptr_full: illegal ADDR_W or AFULL_THRESH");
  end

  logic [ADDR_W:0] r_wbin;
  logic [ADDR_W:0] r_wptr;
  logic            r_wfull;
  logic            r_wovf;

  logic            w_wr_en;
  logic [ADDR_W:0] w_wbin_next;
  logic [ADDR_W:0] w_wgray_next;
  logic [ADDR_W:0] w_rptr_full;

  assign w_wr_en      = winc_i & ~r_wfull;
  assign w_wbin_next  = r_wbin + {{ADDR_W{1'b0}}, w_wr_en};
  assign w_wgray_next = (w_wbin_next >> 1) ^ w_wbin_next;
  // Gray image of the read pointer one full lap ahead: invert the two MSBs.
  assign w_rptr_full  = {~wq2_rptr_i[ADDR_W:ADDR_W-1], wq2_rptr_i[ADDR_W-2:0]};

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_wbin  <= '0;
      r_wptr  <= '0;
      r_wfull <= 1'b0;
      r_wovf  <= 1'b0;
    end else begin
      r_wbin  <= w_wbin_next;
      r_wptr  <= w_wgray_next;
      r_wfull <= (w_wgray_next == w_rptr_full);
      r_wovf  <= r_wovf | (winc_i & r_wfull);
    end
  end

`ifdef AFIFO_WALMOST_FULL_EN
  localparam logic [ADDR_W:0] LP_AFULL = (ADDR_W+1)'(AFULL_THRESH);

  logic [ADDR_W:0] w_rbin;
  logic [ADDR_W:0] w_wcount_next;
  logic            r_walmost;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    w_rbin = '0;
    for (int i = 0; i <= ADDR_W; i++) begin
      w_rbin[i] = ^(wq2_rptr_i >> i);
    end
  end

  assign w_wcount_next = w_wbin_next - w_rbin;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_walmost <= 1'b0;
    end else begin
      r_walmost <= (w_wcount_next >= LP_AFULL);
    end
  end

  assign walmost_full_o = r_walmost;
`else
  assign walmost_full_o = 1'b0;
`endif

  assign wr_en_o = w_wr_en;
  assign waddr_o = r_wbin[ADDR_W-1:0];
  assign wptr_o  = r_wptr;
  assign wfull_o = r_wfull;
  assign wovf_o  = r_wovf;

endmodule

// File: tb/tb_afifo_wptr_full.sv
// Self-checking bench for afifo_wptr_full (ADDR_W=4) against an occupancy-count model.
module tb_afifo_wptr_full;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int PMOD   = 32;
  localparam int AFULL  = 14;

  logic        clk = 1'b0;
  logic        rstn_i;
  logic        winc_i;
  logic [4:0]  wq2_rptr_i;
  logic        wr_en_o;
  logic [3:0]  waddr_o;
  logic [4:0]  wptr_o;
  logic        wfull_o;
  logic        wovf_o;
  logic        walmost_full_o;

  afifo_wptr_full #(.ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .winc_i(winc_i), .wq2_rptr_i(wq2_rptr_i),
    .wr_en_o(wr_en_o), .waddr_o(waddr_o), .wptr_o(wptr_o), .wfull_o(wfull_o),
    .wovf_o(wovf_o), .walmost_full_o(walmost_full_o)
  );

  always #5 clk = ~clk;

  // Gray code must move by exactly one bit whenever it moves.
  property p_gray_step;
    @(posedge clk) disable iff (!rstn_i)
      (wptr_o != $past(wptr_o)) |-> $onehot(wptr_o ^ $past(wptr_o));
  endproperty
  a_gray_step: assert property (p_gray_step);

  int n_pass  = 0;
  int n_total = 0;

  // Model: writes accepted so far and reader position, both mod 2*DEPTH.
  int m_wb, m_rb;
  bit m_full, m_ovf, m_af;
  bit s_wren, e_wren;

  function automatic logic [4:0] gray(input int b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction

  function automatic int occupancy(input int wb, input int rb);
    return (wb - rb + PMOD) % PMOD;
  endfunction

  function automatic bit model_af(input int wb, input int rb);
`ifdef AFIFO_WALMOST_FULL_EN
    return occupancy(wb, rb) >= AFULL;
`else
    return 1'b0;
`endif
  endfunction

  task automatic drive(input bit winc, input int rb);
    bit acc;
    winc_i     = winc;
    m_rb       = rb % PMOD;
    wq2_rptr_i = gray(m_rb);
    #1;
    s_wren = wr_en_o;
    acc    = winc && !m_full;
    e_wren = acc;
    @(posedge clk);
    #1;
    m_ovf  = m_ovf | (winc && m_full);
    m_wb   = (m_wb + int'(acc)) % PMOD;
    m_full = occupancy(m_wb, m_rb) == DEPTH;
    m_af   = model_af(m_wb, m_rb);
  endtask

  task automatic apply_reset();
    rstn_i = 1'b0;
    winc_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    m_wb = 0; m_rb = 0; m_full = 0; m_ovf = 0; m_af = 0;
    wq2_rptr_i = '0;
    rstn_i = 1'b1;
    winc_i = 1'b0;
  endtask

  task automatic test_reset();
    wq2_rptr_i = '0;
    apply_reset();
    n_total++;
    if ({wptr_o, waddr_o, wfull_o, wovf_o, walmost_full_o} !== 12'b0)
      $display("FAIL reset_state: got wptr=%b waddr=%0d full=%b ovf=%b af=%b want all zero",
               wptr_o, waddr_o, wfull_o, wovf_o, walmost_full_o);
    else n_pass++;
    #1;
    n_total++;
    if (wr_en_o !== 1'b0) $display("FAIL reset_wr_en: got %b want 0", wr_en_o);
    else n_pass++;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 0);
      n_total++;
      if (s_wren !== e_wren || wfull_o !== m_full || wptr_o !== gray(m_wb))
        $display("FAIL fill_%0d: got wr_en=%b full=%b wptr=%b want wr_en=%b full=%b wptr=%b",
                 i, s_wren, wfull_o, wptr_o, e_wren, m_full, gray(m_wb));
      else n_pass++;
      if (i == 15) begin
        n_total++;
        if (wfull_o !== 1'b0) $display("FAIL fill_15_not_full: got %b want 0", wfull_o);
        else n_pass++;
      end
    end
    n_total++;
    if ({wfull_o, wptr_o, waddr_o} !== {1'b1, 5'b11000, 4'd0})
      $display("FAIL fill_16_full: got full=%b wptr=%b waddr=%0d want full=1 wptr=11000 waddr=0",
               wfull_o, wptr_o, waddr_o);
    else n_pass++;
  endtask

  task automatic test_overflow();
    drive(1'b1, 0);
    n_total++;
    if ({s_wren, wptr_o, wovf_o, wfull_o} !== {1'b0, 5'b11000, 1'b1, 1'b1})
      $display("FAIL overflow: got wr_en=%b wptr=%b ovf=%b full=%b want wr_en=0 wptr=11000 ovf=1 full=1",
               s_wren, wptr_o, wovf_o, wfull_o);
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 0);
      n_total++;
      if (wovf_o !== 1'b1 || wptr_o !== 5'b11000)
        $display("FAIL overflow_hold_%0d: got ovf=%b wptr=%b want ovf=1 wptr=11000", i, wovf_o, wptr_o);
      else n_pass++;
    end
  endtask

  task automatic test_drain_one();
    drive(1'b0, 1);
    n_total++;
    if (wfull_o !== 1'b0) $display("FAIL drain_clear: got full=%b want 0", wfull_o);
    else n_pass++;
    drive(1'b1, 1);
    n_total++;
    if ({s_wren, wptr_o, wfull_o} !== {1'b1, 5'b11001, 1'b1})
      $display("FAIL drain_write: got wr_en=%b wptr=%b full=%b want wr_en=1 wptr=11001 full=1",
               s_wren, wptr_o, wfull_o);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [4:0] prev;
    bit seen_wrap;
    seen_wrap = 0;
    drive(1'b0, m_wb);
    for (int i = 0; i < 40; i++) begin
      prev = wptr_o;
      drive(1'b1, m_wb);
      if (prev == 5'b10000 && wptr_o == 5'b00000) seen_wrap = 1;
      n_total++;
      if (wptr_o !== gray(m_wb) || waddr_o !== 4'(m_wb) || wfull_o !== m_full
          || $countones(wptr_o ^ prev) > 1)
        $display("FAIL wrap_%0d: got wptr=%b waddr=%0d full=%b prev=%b want wptr=%b waddr=%0d full=%b",
                 i, wptr_o, waddr_o, wfull_o, prev, gray(m_wb), m_wb % DEPTH, m_full);
      else n_pass++;
    end
    n_total++;
    if (!seen_wrap) $display("FAIL wrap_seen: got no 10000->00000 step want one");
    else n_pass++;
  endtask

  task automatic test_random();
    int rb;
    int errs;
    bit w;
    errs = 0;
    rb = m_rb;
    for (int i = 0; i < 300; i++) begin
      w = ($urandom_range(0, 99) < 70);
      if (occupancy(m_wb, rb) > 0 && $urandom_range(0, 99) < 35) rb = (rb + 1) % PMOD;
      drive(w, rb);
      if (s_wren !== e_wren || wptr_o !== gray(m_wb) || waddr_o !== 4'(m_wb) ||
          wfull_o !== m_full || wovf_o !== m_ovf || walmost_full_o !== m_af) begin
        errs++;
        if (errs <= 5)
          $display("FAIL random_%0d: got wr_en=%b wptr=%b full=%b ovf=%b af=%b want wr_en=%b wptr=%b full=%b ovf=%b af=%b",
                   i, s_wren, wptr_o, wfull_o, wovf_o, walmost_full_o,
                   e_wren, gray(m_wb), m_full, m_ovf, m_af);
      end
    end
    n_total++;
    if (errs != 0) $display("FAIL random_summary: got %0d bad cycles want 0", errs);
    else n_pass++;
  endtask

  task automatic test_almost_full();
    apply_reset();
    for (int i = 1; i <= 14; i++) begin
      drive(1'b1, 0);
      if (i >= 13) begin
        n_total++;
        if (walmost_full_o !== m_af)
          $display("FAIL almost_full_%0d: got %b want %b", i, walmost_full_o, m_af);
        else n_pass++;
      end
    end
    drive(1'b0, 2);
    n_total++;
    if (walmost_full_o !== 1'b0 || wfull_o !== 1'b0)
      $display("FAIL almost_full_drain: got af=%b full=%b want af=0 full=0", walmost_full_o, wfull_o);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 20; i++) drive(1'b1, m_rb);
    apply_reset();
    n_total++;
    if ({wptr_o, waddr_o, wfull_o, wovf_o, walmost_full_o} !== 12'b0)
      $display("FAIL mid_reset: got wptr=%b waddr=%0d full=%b ovf=%b af=%b want all zero",
               wptr_o, waddr_o, wfull_o, wovf_o, walmost_full_o);
    else n_pass++;
    drive(1'b1, 0);
    n_total++;
    if ({s_wren, wptr_o, waddr_o} !== {1'b1, 5'b00001, 4'd1})
      $display("FAIL mid_reset_write: got wr_en=%b wptr=%b waddr=%0d want wr_en=1 wptr=00001 waddr=1",
               s_wren, wptr_o, waddr_o);
    else n_pass++;
  endtask

  initial begin
    rstn_i = 1'b0; winc_i = 1'b0; wq2_rptr_i = '0;
    test_reset();
    test_fill();
    test_overflow();
    test_drain_one();
    test_wrap();
    test_random();
    test_almost_full();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
